// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier (MUL/MULH/MULHU) with cancel and a last-result cache
module mul_iter #(
  parameter int WIDTH    = 32,
  parameter int STEP     = 2,
  parameter int CACHE_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult,
  input  logic [9:0]       mul_div_op,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  input  logic             cancel,
  output logic [WIDTH-1:0] mul_result,
  output logic             done,
  output logic             busy
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] mc, mp, hi, lo, hi_s, res;
  logic [2:0] op, dec_op;
  logic [CW-1:0] cnt;
  logic cache_vld, hit;
  logic [WIDTH-1:0] tag_a, tag_b, cache_res;
  logic [2:0] tag_op;
  logic [WIDTH+STEP-1:0] pp, sum;
  logic [2*WIDTH+STEP-1:0] cat;
  logic [2*WIDTH-1:0] nxt;
  logic unused;
  assign unused = ^mul_div_op[9:3];
  assign busy = state != IDLE;
  assign dec_op = mul_div_op[0] ? 3'b001 : mul_div_op[1] ? 3'b010 : mul_div_op[2] ? 3'b100 : 3'b000;
  assign hit = (CACHE_EN != 0) && cache_vld && tag_a == alu_src1 && tag_b == alu_src2 && tag_op == dec_op;
  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP; i++)
      if (lo[i]) pp = pp + ({{STEP{1'b0}}, mc} << i);
  end
  assign sum = {{STEP{1'b0}}, hi} + pp;
  assign cat = {sum, lo};
  assign nxt = cat[2*WIDTH+STEP-1:STEP];
  // signed high half derived from the unsigned product by subtracting the sign-weighted operands
  assign hi_s = nxt[2*WIDTH-1:WIDTH] - (mc[WIDTH-1] ? mp : '0) - (mp[WIDTH-1] ? mc : '0);
  assign res = op[0] ? nxt[WIDTH-1:0] : op[1] ? hi_s : nxt[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mul_result <= '0;
      done <= 1'b0;
      cache_vld <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (cancel) cache_vld <= 1'b0;
          else if (mult) begin
            mc <= alu_src1;
            mp <= alu_src2;
            hi <= '0;
            lo <= alu_src2;
            op <= dec_op;
            cnt <= '0;
            if (dec_op == 3'b000 || hit) begin
              state <= DONE;
              mul_result <= dec_op == 3'b000 ? '0 : cache_res;
              done <= 1'b1;
            end else state <= BUSY;
          end
        BUSY:
          if (cancel) begin
            state <= IDLE;
            cache_vld <= 1'b0;
          end else begin
            hi <= nxt[2*WIDTH-1:WIDTH];
            lo <= nxt[WIDTH-1:0];
            cnt <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              state <= DONE;
              mul_result <= res;
              done <= 1'b1;
              cache_vld <= CACHE_EN != 0;
              tag_a <= mc;
              tag_b <= mp;
              tag_op <= op;
              cache_res <= res;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: randomized and directed checks of mul_iter across several parameter sets
module tb_mul_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] mult = '0;
  logic [9:0] op = '0;
  logic [31:0] src1 = '0, src2 = '0;
  logic cancel = 1'b0;
  logic [31:0] r0, r1;
  logic [15:0] r2, r3;
  logic d0, d1, d2, d3, b0, b1, b2, b3;
  int total = 0, bad = 0;
  logic [31:0] r;
  int lat, bc, dc;
  always #5 clk = ~clk;
  mul_iter #(.WIDTH(32), .STEP(2), .CACHE_EN(1)) u0 (.clk(clk), .reset(reset), .mult(mult[0]), .mul_div_op(op),
    .alu_src1(src1), .alu_src2(src2), .cancel(cancel), .mul_result(r0), .done(d0), .busy(b0));
  mul_iter #(.WIDTH(32), .STEP(2), .CACHE_EN(0)) u1 (.clk(clk), .reset(reset), .mult(mult[1]), .mul_div_op(op),
    .alu_src1(src1), .alu_src2(src2), .cancel(cancel), .mul_result(r1), .done(d1), .busy(b1));
  mul_iter #(.WIDTH(16), .STEP(4), .CACHE_EN(1)) u2 (.clk(clk), .reset(reset), .mult(mult[2]), .mul_div_op(op),
    .alu_src1(src1[15:0]), .alu_src2(src2[15:0]), .cancel(cancel), .mul_result(r2), .done(d2), .busy(b2));
  mul_iter #(.WIDTH(16), .STEP(1), .CACHE_EN(1)) u3 (.clk(clk), .reset(reset), .mult(mult[3]), .mul_div_op(op),
    .alu_src1(src1[15:0]), .alu_src2(src2[15:0]), .cancel(cancel), .mul_result(r3), .done(d3), .busy(b3));
  function automatic logic rd_busy(input int k);
    return k == 0 ? b0 : k == 1 ? b1 : k == 2 ? b2 : b3;
  endfunction
  function automatic logic rd_done(input int k);
    return k == 0 ? d0 : k == 1 ? d1 : k == 2 ? d2 : d3;
  endfunction
  function automatic logic [31:0] rd_res(input int k);
    return k == 0 ? r0 : k == 1 ? r1 : k == 2 ? {16'h0, r2} : {16'h0, r3};
  endfunction
  function automatic logic [31:0] ref_mul(input logic [9:0] o, input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] m, pu, ps;
    longint sa, sb;
    m = (64'd1 << w) - 64'd1;
    pu = (64'(a) & m) * (64'(b) & m);
    sa = w == 32 ? longint'($signed(a)) : longint'($signed(a[15:0]));
    sb = w == 32 ? longint'($signed(b)) : longint'($signed(b[15:0]));
    ps = 64'(sa * sb);
    if (o[0]) return 32'(pu & m);
    if (o[1]) return 32'((ps >> w) & m);
    if (o[2]) return 32'((pu >> w) & m);
    return 32'd0;
  endfunction
  task automatic run(input int k, input logic [9:0] o, input logic [31:0] a, input logic [31:0] b,
                     output logic [31:0] res, output int l, output int nb, output int nd);
    @(negedge clk);
    op = o; src1 = a; src2 = b; mult[k] = 1'b1;
    @(posedge clk);
    l = -1; nb = 0; nd = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) mult[k] = 1'b0;
      if (rd_busy(k)) nb++;
      if (rd_done(k)) begin
        nd++;
        if (l < 0) l = i - 1;
      end
      if (!rd_busy(k)) break;
    end
    res = rd_res(k);
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (r0 !== 32'h0) begin bad++; $display("FAIL reset_result got %h want 0", r0); end
    total++; if (d0 !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", d0); end
    total++; if (b0 !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", b0); end
    reset = 1'b0;
  endtask
  task automatic test_mulh_latency;
    run(0, 10'h002, 32'h2, 32'h8000_0000, r, lat, bc, dc);
    total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_neg got %h want ffffffff", r); end
    total++; if (lat !== 16) begin bad++; $display("FAIL mulh_latency got %0d want 16", lat); end
    total++; if (bc !== 17) begin bad++; $display("FAIL busy_cycles got %0d want 17", bc); end
    total++; if (dc !== 1) begin bad++; $display("FAIL done_cycles got %0d want 1", dc); end
  endtask
  task automatic test_corners;
    logic [9:0] ops [4] = '{10'h001, 10'h004, 10'h002, 10'h002};
    logic [31:0] av [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] ex [4] = '{32'h1, 32'hFFFF_FFFE, 32'h0, 32'h4000_0000};
    for (int i = 0; i < 4; i++) begin
      run(0, ops[i], av[i], av[i], r, lat, bc, dc);
      total++; if (r !== ex[i]) begin bad++; $display("FAIL corner%0d got %h want %h", i, r, ex[i]); end
      total++; if (lat !== 16) begin bad++; $display("FAIL corner%0d_latency got %0d want 16", i, lat); end
    end
  endtask
  task automatic test_cache;
    logic [9:0] ops [5] = '{10'h004, 10'h004, 10'h008, 10'h004, 10'h002};
    int el [5] = '{16, 0, 0, 0, 16};
    logic [31:0] ex [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFE, 32'h0};
    for (int i = 0; i < 5; i++) begin
      run(0, ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, dc);
      total++; if (r !== ex[i]) begin bad++; $display("FAIL cache%0d got %h want %h", i, r, ex[i]); end
      total++; if (lat !== el[i]) begin bad++; $display("FAIL cache%0d_latency got %0d want %0d", i, lat, el[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      run(1, 10'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, dc);
      total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL nocache%0d got %h want fffffffe", i, r); end
      total++; if (lat !== 16) begin bad++; $display("FAIL nocache%0d_latency got %0d want 16", i, lat); end
    end
  endtask
  task automatic test_cancel;
    logic seen = 1'b0;
    run(0, 10'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, dc);
    @(negedge clk);
    op = 10'h001; src1 = 32'd3; src2 = 32'd5; mult[0] = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) mult[0] = 1'b0;
      if (d0) seen = 1'b1;
      if (i == 5) cancel = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    if (d0) seen = 1'b1;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL cancel_done got %b want 0", seen); end
    total++; if (b0 !== 1'b0) begin bad++; $display("FAIL cancel_busy got %b want 0", b0); end
    total++; if (r0 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cancel_hold got %h want fffffffe", r0); end
    run(0, 10'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bc, dc);
    total++; if (lat !== 16) begin bad++; $display("FAIL cancel_invalidate got %0d want 16", lat); end
  endtask
  task automatic test_reset_mid;
    logic seen = 1'b0;
    @(negedge clk);
    op = 10'h001; src1 = 32'd3; src2 = 32'd5; mult[0] = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) mult[0] = 1'b0;
      if (d0) seen = 1'b1;
      if (i == 8) reset = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++; if (r0 !== 32'h0) begin bad++; $display("FAIL midreset_result got %h want 0", r0); end
    total++; if ({seen, d0, b0} !== 3'b000) begin bad++; $display("FAIL midreset_flags got %b want 000", {seen, d0, b0}); end
    run(0, 10'h001, 32'd7, 32'd6, r, lat, bc, dc);
    total++; if (r !== 32'h2A) begin bad++; $display("FAIL after_reset got %h want 2a", r); end
    total++; if (lat !== 16) begin bad++; $display("FAIL after_reset_latency got %0d want 16", lat); end
  endtask
  task automatic test_params;
    run(2, 10'h002, 32'h8000, 32'h2, r, lat, bc, dc);
    total++; if (r !== 32'hFFFF) begin bad++; $display("FAIL w16s4 got %h want ffff", r); end
    total++; if (lat !== 4) begin bad++; $display("FAIL w16s4_latency got %0d want 4", lat); end
    run(3, 10'h004, 32'hFFFF, 32'hFFFF, r, lat, bc, dc);
    total++; if (r !== 32'hFFFE) begin bad++; $display("FAIL w16s1 got %h want fffe", r); end
    total++; if (lat !== 16) begin bad++; $display("FAIL w16s1_latency got %0d want 16", lat); end
  endtask
  task automatic test_random;
    int ks [3] = '{0, 2, 3};
    int ws [3] = '{32, 16, 16};
    int ns [3] = '{16, 4, 16};
    logic [9:0] o;
    logic [31:0] a, b, e;
    int el;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 25; i++) begin
        o = 10'($urandom_range(0, 1023));
        a = $urandom;
        b = $urandom;
        if (i % 7 == 0) a = ws[j] == 32 ? 32'h8000_0000 : 32'h8000;
        e = ref_mul(o, a, b, ws[j]);
        el = o[2:0] == 3'b000 ? 0 : ns[j];
        run(ks[j], o, a, b, r, lat, bc, dc);
        total++; if (r !== e) begin bad++; $display("FAIL rand_u%0d op=%h a=%h b=%h got %h want %h", ks[j], o, a, b, r, e); end
        total++; if (lat !== el) begin bad++; $display("FAIL rand_u%0d_latency got %0d want %0d", ks[j], lat, el); end
      end
  endtask
  initial begin
    test_reset;
    test_mulh_latency;
    test_corners;
    test_cache;
    test_cancel;
    test_reset_mid;
    test_params;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
